// File: rtl/mem_stage_top.sv
// MIPS memory stage: branch resolution, multi-cycle data memory access with
// upstream stall, and the MEM/WB pipeline latch feeding write-back.
module mem_stage_top #(
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 8,
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  wb_ctl,
  input  logic        branch,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] EX_MEM_NPC,
  input  logic        zero,
  input  logic [31:0] alu_result,
  input  logic [31:0] rdata2out,
  input  logic [4:0]  five_bit_muxout,
  output logic        pcsrc,
  output logic [31:0] branch_target,
  output logic        stall,
  output logic [1:0]  mem_wb_ctl,
  output logic [31:0] mem_read_data,
  output logic [31:0] mem_alu_result,
  output logic [4:0]  mem_write_reg
);

  localparam int CNT_W = $clog2(MEM_LAT) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LAT - 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              op, is_load, done;
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       load_data;
  logic [31:0]       mem [DEPTH];

  logic [1:0]  mem_wb_ctl_q, mem_wb_ctl_d;
  logic [31:0] mem_read_data_q, mem_read_data_d;
  logic [31:0] mem_alu_result_q, mem_alu_result_d;
  logic [4:0]  mem_write_reg_q, mem_write_reg_d;

  // Byte offset and bits above the word index are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{alu_result[31:ADDR_W+2], alu_result[1:0]};

  assign op            = memread | memwrite;
  assign is_load       = memread & ~memwrite;
  assign word_idx      = alu_result[ADDR_W+1:2];
  assign load_data     = mem[word_idx];
  assign pcsrc         = branch & zero;
  assign branch_target = EX_MEM_NPC;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (MEM_LAT == 1) begin
          done = op;
        end else if (op) begin
          stall   = 1'b1;
          state_d = BUSY;
          cnt_d   = CNT_W'(1);
        end
      end
      BUSY: begin
        if (cnt_q < LAST_CNT) begin
          stall = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          done    = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: the memory array has no reset; only the write enable is gated by rst.
  always_ff @(posedge clk) begin
    if (!rst && done && memwrite) begin
      mem[word_idx] <= rdata2out;
    end
  end

  // A stalled cycle pushes a bubble: control cleared, data fields held.
  always_comb begin
    mem_wb_ctl_d     = 2'b00;
    mem_read_data_d  = mem_read_data_q;
    mem_alu_result_d = mem_alu_result_q;
    mem_write_reg_d  = mem_write_reg_q;
    if (!stall) begin
      mem_wb_ctl_d     = wb_ctl;
      mem_read_data_d  = is_load ? load_data : 32'h0;
      mem_alu_result_d = alu_result;
      mem_write_reg_d  = five_bit_muxout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_wb_ctl_q     <= 2'b00;
      mem_read_data_q  <= 32'h0;
      mem_alu_result_q <= 32'h0;
      mem_write_reg_q  <= 5'd0;
    end else begin
      mem_wb_ctl_q     <= mem_wb_ctl_d;
      mem_read_data_q  <= mem_read_data_d;
      mem_alu_result_q <= mem_alu_result_d;
      mem_write_reg_q  <= mem_write_reg_d;
    end
  end

  assign mem_wb_ctl     = mem_wb_ctl_q;
  assign mem_read_data  = mem_read_data_q;
  assign mem_alu_result = mem_alu_result_q;
  assign mem_write_reg  = mem_write_reg_q;

endmodule

// File: doc/mem_stage_top.md
Name: mem_stage_top

Overview:
- Memory stage of the 5-stage MIPS pipeline. It consumes the EX/MEM latch outputs of the execute stage.
- Resolves the branch decision (PCSrc) toward fetch.
- Performs load/store against an internal word-addressed data memory with configurable access latency. While a multi-cycle access is in progress it raises a stall.
- Contains the MEM/WB latch feeding write-back.

Parameters:
- DEPTH, 256: data memory size in 32-bit words; power of two.
- ADDR_W, 8: log2(DEPTH); word-index width.
- MEM_LAT, 1: cycles per load/store access; must be >= 1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- wb_ctl  in  2  write-back control from EX/MEM ([1]=regwrite, [0]=memtoreg)
- branch  in  1  branch instruction flag from EX/MEM
- memread  in  1  load request
- memwrite  in  1  store request
- EX_MEM_NPC  in  32  branch target from EX/MEM
- zero  in  1  ALU zero flag from EX/MEM
- alu_result  in  32  ALU result; byte address for loads/stores
- rdata2out  in  32  store data
- five_bit_muxout  in  5  destination register
- pcsrc  out  1  combinational: branch & zero
- branch_target  out  32  combinational passthrough of EX_MEM_NPC
- stall  out  1  hold upstream stages and PC this cycle
- mem_wb_ctl  out  2  MEM/WB registered write-back control
- mem_read_data  out  32  MEM/WB registered load data
- mem_alu_result  out  32  MEM/WB registered ALU result
- mem_write_reg  out  5  MEM/WB registered destination register

Behaviour:
- **Reset:** synchronous, active-high.
  - MEM/WB outputs clear to 0.
  - FSM goes to IDLE and the access counter to 0; stall is 0 in the following cycle.
  - Memory contents are NOT cleared.
- **Addressing:** word index = alu_result[ADDR_W+1:2].
  - alu_result[1:0] is ignored (no misalignment trap).
  - Higher address bits are ignored, so the address wraps modulo DEPTH words.
- **Access op:** an access op is memread | memwrite. If both are asserted, the op is treated as a store and the loaded data is 0.
- **FSM:** IDLE, BUSY; cnt is ceil(log2(MEM_LAT))+1 bits.
  - IDLE, op present, MEM_LAT > 1: stall=1; go to BUSY with cnt=1.
  - BUSY, cnt < MEM_LAT-1: stall=1; cnt increments.
  - BUSY, cnt == MEM_LAT-1: stall=0 (done cycle); go to IDLE with cnt=0.
  - IDLE, op present, MEM_LAT == 1: the op completes in the same cycle and stall stays 0.
  - IDLE, no op: stall=0 and the FSM stays in IDLE.
- **Access timing:** an op presented at cycle t holds stall high for cycles t..t+MEM_LAT-2.
  - The store commits at the clock edge ending cycle t+MEM_LAT-1.
  - Load data is captured into mem_read_data at that same edge.
  - The memory read is asynchronous on the word index.
  - Upstream must hold all EX/MEM inputs stable while stall=1.
- **MEM/WB latch:** updates every edge.
  - If stall=1, it loads a bubble: mem_wb_ctl=00, other fields hold their previous values.
  - Otherwise it loads wb_ctl, alu_result and five_bit_muxout.
  - mem_read_data is loaded with memory data for a load, and 0 for a non-load or store.
- **Branch resolution:** pcsrc and branch_target are purely combinational and unaffected by stall. Flushing is owned by the hazard unit, not this block.
- **Reset mid-access:** the FSM aborts, no store commits, and MEM/WB clears. The stalled instruction is lost; upstream is also reset.
- **Back-to-back ops:** ops after the done cycle start a fresh access from IDLE with no idle gap. The done cycle's op is the current one.

Test Plan:
- **Reset:** rst=1 for 2 cycles with memwrite=1 → all MEM/WB outputs 0, stall=0, and a later load from the same address does not return the written data.
- **Store then load, MEM_LAT=1:**
  - Stimulus: store rdata2out=0xDEADBEEF at alu_result=0x10, then a load at 0x10 with wb_ctl=11, five_bit_muxout=5.
  - Response: stall never asserts; one cycle later mem_read_data=0xDEADBEEF, mem_wb_ctl=11, mem_write_reg=5.
- **Multi-cycle load, MEM_LAT=3:** load at cycle t → stall=1 in cycles t and t+1, stall=0 in t+2.
  - mem_wb_ctl=00 after edges t and t+1.
  - After edge t+2, mem_wb_ctl=wb_ctl and load data appears.
- **Branch:**
  - branch=1, zero=1, EX_MEM_NPC=0x40 → pcsrc=1 and branch_target=0x40 in the same cycle.
  - branch=1, zero=0 → pcsrc=0.
- **Wrap and both-asserted, DEPTH=256:**
  - Store 0x1234 at 0x400, then load at 0x000 → reads 0x1234.
  - memread=memwrite=1 → store occurs and mem_read_data=0.
- **Reset mid-access, MEM_LAT=4:** rst asserted in cycle 2 of a store → no memory change, and stall=0 and mem_wb_ctl=00 in the next cycle.
